// File: rtl/memory_turn_engine.sv
// Turn sequencer for a memory (pairs) card game: collects two picks, shows them for
// a fixed time, scores matches, rotates players on a miss and reports the winner.
module memory_turn_engine #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_PAIRS   = 8,
    parameter int SYM_W       = 4,
    parameter int IDX_W       = 5,
    parameter int REVEAL_CYC  = 4,
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int SW = $clog2(NUM_PAIRS + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_select,
    input  logic                      i_empty,
    input  logic [IDX_W-1:0]          i_card_idx,
    input  logic [SYM_W-1:0]          i_card_sym,
    input  logic                      i_new_game,
    output logic [IDX_W-1:0]          o_selected1,
    output logic [IDX_W-1:0]          o_selected2,
    output logic                      o_busy,
    output logic                      o_res_valid,
    output logic                      o_par,
    output logic [PW-1:0]             o_player,
    output logic [NUM_PLAYERS*SW-1:0] o_scores,
    output logic                      o_game_over,
    output logic [PW-1:0]             o_winner,
    output logic                      o_tie
);

    localparam int TW = (REVEAL_CYC > 2) ? $clog2(REVEAL_CYC) : 1;

    typedef enum logic [2:0] {
        S_FIRST,
        S_SECOND,
        S_REVEAL,
        S_RESOLVE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [IDX_W-1:0]  r_selected1;
    logic [IDX_W-1:0]  r_selected2;
    logic [SYM_W-1:0]  r_sym1;
    logic [SYM_W-1:0]  r_sym2;
    logic [TW-1:0]     r_timer;
    logic              r_par;
    logic [PW-1:0]     r_player;
    logic [SW-1:0]     r_pairsFound;
    logic [SW-1:0]     r_scores [NUM_PLAYERS];
    logic [PW-1:0]     r_winner;
    logic              r_tie;

    logic              w_firstPick;
    logic              w_secondPick;
    logic              w_match;
    logic              w_gameEnds;
    logic [SW-1:0]     w_nextPairs;
    logic [SW-1:0]     w_nextScores [NUM_PLAYERS];
    logic [SW-1:0]     w_maxScore;
    logic [3:0]        w_maxCount;
    logic [PW-1:0]     w_winnerNext;
    logic [PW-1:0]     w_playerNext;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_FIRST;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_firstPick  = 1'b0;
        w_secondPick = 1'b0;
        if (i_new_game) begin
            w_nextState = S_FIRST;
        end else begin
            case (r_state)
                S_FIRST: begin
                    if (i_select && i_empty) begin
                        w_firstPick = 1'b1;
                        w_nextState = S_SECOND;
                    end
                end
                S_SECOND: begin
                    if (i_select && i_empty && (i_card_idx != r_selected1)) begin
                        w_secondPick = 1'b1;
                        w_nextState  = S_REVEAL;
                    end
                end
                S_REVEAL: begin
                    if (r_timer == '0) begin
                        w_nextState = S_RESOLVE;
                    end
                end
                S_RESOLVE: w_nextState = w_gameEnds ? S_DONE : S_FIRST;
                S_DONE:    w_nextState = S_DONE;
                default:   w_nextState = S_FIRST;
            endcase
        end
    end

    // Post-resolution score view; the winner is judged on these so DONE sees the final pair.
    always_comb begin
        w_match      = (r_sym1 == r_sym2);
        w_nextPairs  = w_match ? r_pairsFound + 1'b1 : r_pairsFound;
        w_gameEnds   = w_match && (w_nextPairs == SW'(NUM_PAIRS));
        w_playerNext = (r_player == PW'(NUM_PLAYERS - 1)) ? '0 : r_player + 1'b1;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_nextScores[p] = r_scores[p];
            if (w_match && (PW'(p) == r_player) && (r_scores[p] < SW'(NUM_PAIRS))) begin
                w_nextScores[p] = r_scores[p] + 1'b1;
            end
        end
        w_maxScore   = '0;
        w_winnerNext = '0;
        w_maxCount   = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_nextScores[p] > w_maxScore) begin
                w_maxScore   = w_nextScores[p];
                w_winnerNext = PW'(p);
            end
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_nextScores[p] == w_maxScore) begin
                w_maxCount = w_maxCount + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_selected1  <= '0;
            r_selected2  <= '0;
            r_sym1       <= '0;
            r_sym2       <= '0;
            r_timer      <= '0;
            r_par        <= 1'b0;
            r_player     <= '0;
            r_pairsFound <= '0;
            r_winner     <= '0;
            r_tie        <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) r_scores[p] <= '0;
        end else if (i_new_game) begin
            r_selected1  <= '0;
            r_selected2  <= '0;
            r_timer      <= '0;
            r_par        <= 1'b0;
            r_player     <= '0;
            r_pairsFound <= '0;
            r_winner     <= '0;
            r_tie        <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) r_scores[p] <= '0;
        end else if (w_firstPick) begin
            r_selected1 <= i_card_idx;
            r_sym1      <= i_card_sym;
        end else if (w_secondPick) begin
            r_selected2 <= i_card_idx;
            r_sym2      <= i_card_sym;
            r_timer     <= TW'(REVEAL_CYC - 1);
        end else if (r_state == S_REVEAL) begin
            if (r_timer != '0) begin
                r_timer <= r_timer - 1'b1;
            end else begin
                r_par <= w_match;
            end
        end else if (r_state == S_RESOLVE) begin
            r_pairsFound <= w_nextPairs;
            for (int p = 0; p < NUM_PLAYERS; p++) r_scores[p] <= w_nextScores[p];
            if (!w_match) begin
                r_player <= w_playerNext;
            end
            if (w_gameEnds) begin
                r_winner <= w_winnerNext;
                r_tie    <= (w_maxCount > 4'd1);
            end
        end
    end

    always_comb begin
        o_scores = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            o_scores[p*SW +: SW] = r_scores[p];
        end
    end

    assign o_selected1 = r_selected1;
    assign o_selected2 = r_selected2;
    assign o_busy      = (r_state == S_REVEAL) || (r_state == S_RESOLVE);
    assign o_res_valid = (r_state == S_RESOLVE);
    assign o_par       = r_par;
    assign o_player    = r_player;
    assign o_game_over = (r_state == S_DONE);
    assign o_winner    = r_winner;
    assign o_tie       = r_tie;

endmodule

// File: tb/tb_memory_turn_engine.sv
// Bench for memory_turn_engine: three instances (defaults, two-pair board, three players)
// share one stimulus bus; a gated select/new_game picks which instance is being played.
module tb_memory_turn_engine;

    localparam int REVEAL_CYC = 4;

    typedef struct {
        int dut;
        int idx1, sym1, idx2, sym2;
        int expPar, expPlayer, expScores, expGameOver, expWinner, expTie;
        int skipFirst, pokeReveal;
    } vec_t;

    typedef struct {
        int par;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       select;
    logic       empty;
    logic       newGame;
    logic [4:0] cardIdx;
    logic [3:0] cardSym;
    int         dutSel;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    vec_t vecs[14];

    always #5 clk = ~clk;

    logic [4:0] a_sel1, a_sel2, b_sel1, b_sel2, c_sel1, c_sel2;
    logic       a_busy, a_rv, a_par, a_go, a_tie;
    logic       b_busy, b_rv, b_par, b_go, b_tie;
    logic       c_busy, c_rv, c_par, c_go, c_tie;
    logic [0:0] a_player, a_winner, b_player, b_winner;
    logic [1:0] c_player, c_winner;
    logic [7:0] a_scores;
    logic [3:0] b_scores;
    logic [11:0] c_scores;

    memory_turn_engine u_a (
        .i_clk(clk), .i_rst(rst), .i_select(select && dutSel == 0), .i_empty(empty),
        .i_card_idx(cardIdx), .i_card_sym(cardSym), .i_new_game(newGame && dutSel == 0),
        .o_selected1(a_sel1), .o_selected2(a_sel2), .o_busy(a_busy), .o_res_valid(a_rv),
        .o_par(a_par), .o_player(a_player), .o_scores(a_scores), .o_game_over(a_go),
        .o_winner(a_winner), .o_tie(a_tie)
    );

    memory_turn_engine #(.NUM_PAIRS(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_select(select && dutSel == 1), .i_empty(empty),
        .i_card_idx(cardIdx), .i_card_sym(cardSym), .i_new_game(newGame && dutSel == 1),
        .o_selected1(b_sel1), .o_selected2(b_sel2), .o_busy(b_busy), .o_res_valid(b_rv),
        .o_par(b_par), .o_player(b_player), .o_scores(b_scores), .o_game_over(b_go),
        .o_winner(b_winner), .o_tie(b_tie)
    );

    memory_turn_engine #(.NUM_PLAYERS(3)) u_c (
        .i_clk(clk), .i_rst(rst), .i_select(select && dutSel == 2), .i_empty(empty),
        .i_card_idx(cardIdx), .i_card_sym(cardSym), .i_new_game(newGame && dutSel == 2),
        .o_selected1(c_sel1), .o_selected2(c_sel2), .o_busy(c_busy), .o_res_valid(c_rv),
        .o_par(c_par), .o_player(c_player), .o_scores(c_scores), .o_game_over(c_go),
        .o_winner(c_winner), .o_tie(c_tie)
    );

    logic [4:0]  obsSel1, obsSel2;
    logic        obsBusy, obsResValid, obsPar, obsGameOver, obsTie;
    logic [3:0]  obsPlayer, obsWinner;
    logic [15:0] obsScores;

    always_comb begin
        obsSel1 = a_sel1; obsSel2 = a_sel2; obsBusy = a_busy; obsResValid = a_rv;
        obsPar = a_par; obsGameOver = a_go; obsTie = a_tie;
        obsPlayer = 4'(a_player); obsWinner = 4'(a_winner); obsScores = 16'(a_scores);
        if (dutSel == 1) begin
            obsSel1 = b_sel1; obsSel2 = b_sel2; obsBusy = b_busy; obsResValid = b_rv;
            obsPar = b_par; obsGameOver = b_go; obsTie = b_tie;
            obsPlayer = 4'(b_player); obsWinner = 4'(b_winner); obsScores = 16'(b_scores);
        end else if (dutSel == 2) begin
            obsSel1 = c_sel1; obsSel2 = c_sel2; obsBusy = c_busy; obsResValid = c_rv;
            obsPar = c_par; obsGameOver = c_go; obsTie = c_tie;
            obsPlayer = 4'(c_player); obsWinner = 4'(c_winner); obsScores = 16'(c_scores);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (dut %0d): got %0h expected %0h", name, dutSel, act, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input int sym, input bit emp);
        @(negedge clk);
        select  = 1'b1;
        empty   = emp;
        cardIdx = 5'(idx);
        cardSym = 4'(sym);
        @(negedge clk);
        select  = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "Sel1"}, 32'(obsSel1), 0);
        checkOutput({tag, "Sel2"}, 32'(obsSel2), 0);
        checkOutput({tag, "Busy"}, 32'(obsBusy), 0);
        checkOutput({tag, "ResValid"}, 32'(obsResValid), 0);
        checkOutput({tag, "Par"}, 32'(obsPar), 0);
        checkOutput({tag, "Player"}, 32'(obsPlayer), 0);
        checkOutput({tag, "Scores"}, 32'(obsScores), 0);
        checkOutput({tag, "GameOver"}, 32'(obsGameOver), 0);
        checkOutput({tag, "Winner"}, 32'(obsWinner), 0);
        checkOutput({tag, "Tie"}, 32'(obsTie), 0);
    endtask

    task automatic playPair(input vec_t v);
        exp_t e;
        int   cyc;
        bit   seen;
        dutSel = v.dut;
        #1;
        if (v.skipFirst != 0) begin
            applyStimulus(v.idx1, v.sym1, 1'b1);
            checkOutput("firstIdx", 32'(obsSel1), 32'(v.idx1));
            applyStimulus(v.idx1, v.sym1, 1'b1);
            applyStimulus(v.idx1, v.sym1, 1'b0);
            applyStimulus(13, v.sym2, 1'b0);
            checkOutput("ignoredBusy", 32'(obsBusy), 0);
            checkOutput("ignoredResValid", 32'(obsResValid), 0);
        end else begin
            applyStimulus(v.idx1, v.sym1, 1'b1);
        end
        @(negedge clk);
        select  = 1'b1;
        empty   = 1'b1;
        cardIdx = 5'(v.idx2);
        cardSym = 4'(v.sym2);
        sb.push_back('{v.expPar, REVEAL_CYC + 1});
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (v.pokeReveal != 0 && cyc == 2) begin
                checkOutput("revealBusy", 32'(obsBusy), 1);
                checkOutput("revealSel2", 32'(obsSel2), 32'(v.idx2));
            end
            if (v.pokeReveal != 0 && cyc < 3) begin
                select  = 1'b1;
                cardIdx = 5'd14;
            end else begin
                select = 1'b0;
            end
            if (obsResValid) seen = 1'b1;
        end
        select = 1'b0;
        if (!seen) begin
            checkOutput("resTimeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            checkOutput("latency", 32'(cyc), 32'(e.lat));
            checkOutput("par", 32'(obsPar), 32'(e.par));
            checkOutput("busyResolve", 32'(obsBusy), 1);
            @(negedge clk);
            checkOutput("resPulse", 32'(obsResValid), 0);
            checkOutput("parHeld", 32'(obsPar), 32'(e.par));
            checkOutput("player", 32'(obsPlayer), 32'(v.expPlayer));
            checkOutput("scores", 32'(obsScores), 32'(v.expScores));
            checkOutput("gameOver", 32'(obsGameOver), 32'(v.expGameOver));
            checkOutput("sel1", 32'(obsSel1), 32'(v.idx1));
            checkOutput("sel2", 32'(obsSel2), 32'(v.idx2));
            if (v.expGameOver != 0) begin
                checkOutput("winner", 32'(obsWinner), 32'(v.expWinner));
                checkOutput("tie", 32'(obsTie), 32'(v.expTie));
            end
        end
    endtask

    task automatic runRows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) playPair(vecs[i]);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int rvSeen;
        //            dut i1 s1 i2 s2 par pl scores go win tie skip poke
        vecs[0]  = '{0,  3, 5, 7, 5, 1, 0, 'h01, 0, 0, 0, 0, 0};
        vecs[1]  = '{0,  1, 2, 4, 9, 0, 1, 'h01, 0, 0, 0, 0, 0};
        vecs[2]  = '{0,  2, 3, 5, 4, 0, 0, 'h01, 0, 0, 0, 0, 0};
        vecs[3]  = '{0,  8, 6, 9, 7, 0, 1, 'h01, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 10, 1,11, 1, 1, 1, 'h11, 0, 0, 0, 0, 0};
        vecs[5]  = '{0,  6, 3,12, 3, 1, 1, 'h21, 0, 0, 0, 1, 1};
        vecs[6]  = '{1,  0, 1, 1, 1, 1, 0, 'h1,  0, 0, 0, 0, 0};
        vecs[7]  = '{1,  2, 2, 3, 2, 1, 0, 'h2,  1, 0, 0, 0, 0};
        vecs[8]  = '{1,  0, 4, 1, 4, 1, 0, 'h1,  0, 0, 0, 0, 0};
        vecs[9]  = '{1,  2, 5, 3, 6, 0, 1, 'h1,  0, 0, 0, 0, 0};
        vecs[10] = '{1,  4, 7, 5, 7, 1, 1, 'h5,  1, 0, 1, 0, 0};
        vecs[11] = '{2,  0, 1, 1, 2, 0, 1, 'h0,  0, 0, 0, 0, 0};
        vecs[12] = '{2,  2, 1, 3, 2, 0, 2, 'h0,  0, 0, 0, 0, 0};
        vecs[13] = '{2,  4, 1, 5, 2, 0, 0, 'h0,  0, 0, 0, 0, 0};

        rst = 1'b1; select = 1'b0; empty = 1'b0; newGame = 1'b0;
        cardIdx = '0; cardSym = '0; dutSel = 0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            dutSel = d;
            #1;
            checkIdle("reset");
        end
        @(negedge clk);
        rst = 1'b0;

        runRows(0, 7);

        // Finished two-pair game: picks are ignored, then new_game wins over a same-cycle pick.
        dutSel = 1;
        applyStimulus(3, 1, 1'b1);
        checkOutput("doneHoldGameOver", 32'(obsGameOver), 1);
        checkOutput("doneHoldSel1", 32'(obsSel1), 2);
        checkOutput("doneHoldBusy", 32'(obsBusy), 0);
        @(negedge clk);
        newGame = 1'b1; select = 1'b1; empty = 1'b1; cardIdx = 5'd9;
        @(negedge clk);
        newGame = 1'b0; select = 1'b0;
        checkIdle("newGame");

        runRows(8, 13);

        // Reset in the middle of a reveal drops the pending pair.
        dutSel = 0;
        applyStimulus(15, 1, 1'b1);
        applyStimulus(16, 1, 1'b1);
        @(negedge clk);
        checkOutput("preResetBusy", 32'(obsBusy), 1);
        #2 rst = 1'b1;
        #1 checkIdle("asyncReset");
        @(negedge clk);
        rst = 1'b0;
        rvSeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (obsResValid) rvSeen++;
        end
        checkOutput("noResAfterReset", 32'(rvSeen), 0);
        checkOutput("scoresAfterReset", 32'(obsScores), 0);
        playPair('{0, 17, 8, 18, 8, 1, 0, 'h01, 0, 0, 0, 0, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
